// File: rtl/consmax_lanes_if.sv
// Stream and LUT-programming bundle for the consmax_lanes exponent unit.
// The master drives beats and LUT writes; the slave (the unit) returns results.
interface consmax_lanes_if #(
    parameter int NUM_LANE  = 4,
    parameter int IDATA_BIT = 8,
    parameter int ODATA_BIT = 8,
    parameter int CDATA_BIT = 8,
    parameter int LUT_DATA  = 8
);
    localparam int LUT_ADDR = IDATA_BIT / 2;

    logic [CDATA_BIT-1:0]          cfg_shift;
    logic                          lut_wen;
    logic [LUT_ADDR:0]             lut_waddr;
    logic [LUT_DATA-1:0]           lut_wdata;
    logic [NUM_LANE*IDATA_BIT-1:0] idata;
    logic                          idata_valid;
    logic                          idata_ready;
    logic [NUM_LANE*ODATA_BIT-1:0] odata;
    logic                          odata_valid;
    logic                          odata_ready;

    modport master (
        output cfg_shift, lut_wen, lut_waddr, lut_wdata, idata, idata_valid, odata_ready,
        input  idata_ready, odata, odata_valid
    );

    modport slave (
        input  cfg_shift, lut_wen, lut_waddr, lut_wdata, idata, idata_valid, odata_ready,
        output idata_ready, odata, odata_valid
    );
endinterface

// File: rtl/consmax_lanes.sv
// Multi-lane ConSmax exponent: e(x) = LUT_HI[x_hi] * LUT_LO[x_lo] >> shift, saturated, 3-stage pipe.
// Define CONSMAX_ROUND_EN to round half-up in the final shift instead of truncating.
module consmax_lanes #(
    parameter int NUM_LANE  = 4,
    parameter int IDATA_BIT = 8,
    parameter int ODATA_BIT = 8,
    parameter int CDATA_BIT = 8,
    parameter int LUT_DATA  = 8
) (
    input logic clk,
    input logic rst,
    consmax_lanes_if.slave bus
);
    localparam int LUT_ADDR  = IDATA_BIT / 2;
    localparam int LUT_DEPTH = 2 ** LUT_ADDR;
    localparam int PROD_BIT  = 2 * LUT_DATA;
    localparam logic [PROD_BIT:0] SAT_LIMIT = (PROD_BIT + 1)'((2 ** ODATA_BIT) - 1);

    logic [LUT_DATA-1:0] lut_hi [LUT_DEPTH];
    logic [LUT_DATA-1:0] lut_lo [LUT_DEPTH];

    logic stall;
    logic ready;
    logic accept;

    logic [LUT_DATA-1:0] rd_hi [NUM_LANE];
    logic [LUT_DATA-1:0] rd_lo [NUM_LANE];

    logic                 s1_valid;
    logic [CDATA_BIT-1:0] s1_shift;
    logic [LUT_DATA-1:0]  s1_hi [NUM_LANE];
    logic [LUT_DATA-1:0]  s1_lo [NUM_LANE];

    logic                 s2_valid;
    logic [CDATA_BIT-1:0] s2_shift;
    logic [PROD_BIT-1:0]  s2_prod [NUM_LANE];

    logic [NUM_LANE*ODATA_BIT-1:0] s3_res;
    logic [NUM_LANE*ODATA_BIT-1:0] odata_q;
    logic                          odata_valid_q;

    // A single global stall keeps every stage frozen while the output is held.
    assign stall           = odata_valid_q & ~bus.odata_ready;
    assign ready           = ~stall & ~bus.lut_wen;
    assign accept          = bus.idata_valid & ready;
    assign bus.idata_ready = ready;
    assign bus.odata       = odata_q;
    assign bus.odata_valid = odata_valid_q;

    function automatic logic [ODATA_BIT-1:0] shift_sat(input logic [PROD_BIT-1:0]  prod,
                                                       input logic [CDATA_BIT-1:0] shift);
        logic [PROD_BIT:0] sum;
        logic [PROD_BIT:0] shifted;
        sum = {1'b0, prod};
`ifdef CONSMAX_ROUND_EN
        if (shift != '0 && int'(shift) < PROD_BIT) begin
            sum = sum + ((PROD_BIT + 1)'(1) << (shift - CDATA_BIT'(1)));
        end
`endif
        shifted = sum >> shift;
        if (int'(shift) >= PROD_BIT) begin
            return '0;
        end else if (shifted > SAT_LIMIT) begin
            return '1;
        end else begin
            return shifted[ODATA_BIT-1:0];
        end
    endfunction

    // Both tables share one write port; the MSB of the address picks the table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_hi[i] <= '0;
                lut_lo[i] <= '0;
            end
        end else if (bus.lut_wen) begin
            if (bus.lut_waddr[LUT_ADDR]) begin
                lut_hi[bus.lut_waddr[LUT_ADDR-1:0]] <= bus.lut_wdata;
            end else begin
                lut_lo[bus.lut_waddr[LUT_ADDR-1:0]] <= bus.lut_wdata;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANE; i++) begin
            rd_hi[i] = lut_hi[bus.idata[i*IDATA_BIT+LUT_ADDR +: LUT_ADDR]];
            rd_lo[i] = lut_lo[bus.idata[i*IDATA_BIT +: LUT_ADDR]];
        end
    end

    always_comb begin
        s3_res = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            s3_res[i*ODATA_BIT +: ODATA_BIT] = shift_sat(s2_prod[i], s2_shift);
        end
    end

    // The shift travels with its beat so later cfg_shift changes never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_shift      <= '0;
            s2_valid      <= 1'b0;
            s2_shift      <= '0;
            odata_q       <= '0;
            odata_valid_q <= 1'b0;
            for (int i = 0; i < NUM_LANE; i++) begin
                s1_hi[i]   <= '0;
                s1_lo[i]   <= '0;
                s2_prod[i] <= '0;
            end
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_shift <= bus.cfg_shift;
                for (int i = 0; i < NUM_LANE; i++) begin
                    s1_hi[i] <= rd_hi[i];
                    s1_lo[i] <= rd_lo[i];
                end
            end
            s2_valid <= s1_valid;
            s2_shift <= s1_shift;
            for (int i = 0; i < NUM_LANE; i++) begin
                s2_prod[i] <= PROD_BIT'(s1_hi[i]) * PROD_BIT'(s1_lo[i]);
            end
            odata_valid_q <= s2_valid;
            odata_q       <= s3_res;
        end
    end
endmodule

// File: tb/tb_consmax_lanes.sv
// Directed bench for consmax_lanes: reset, LUT programming, saturation, stall, rounding, mid-run reset.
module tb_consmax_lanes;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    consmax_lanes_if bus ();

    consmax_lanes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_lut(input logic [4:0] addr, input logic [7:0] data);
        bus.lut_wen   = 1'b1;
        bus.lut_waddr = addr;
        bus.lut_wdata = data;
        step();
        bus.lut_wen   = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] data, input logic [7:0] shift);
        bus.idata       = data;
        bus.cfg_shift   = shift;
        bus.idata_valid = 1'b1;
        step();
        bus.idata_valid = 1'b0;
    endtask

    // Accept one beat, confirm it is not early, then compare it three edges after acceptance.
    task automatic run_beat(input string tag, input logic [31:0] data, input logic [7:0] shift,
                            input logic [31:0] expected);
        apply_stimulus(data, shift);
        step();
        check_output({tag, " early valid"}, 32'(bus.odata_valid), 32'd0);
        step();
        check_output({tag, " valid"}, 32'(bus.odata_valid), 32'd1);
        check_output({tag, " data"}, bus.odata, expected);
        step();
    endtask

    logic [31:0] in_data [6];
    logic [31:0] exp_out [6];
    int          in_idx;
    int          out_idx;
    int          stall_left;
    bit          stall_started;

    initial begin
        bus.cfg_shift   = '0;
        bus.lut_wen     = 1'b0;
        bus.lut_waddr   = '0;
        bus.lut_wdata   = '0;
        bus.idata       = '0;
        bus.idata_valid = 1'b0;
        bus.odata_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_output("reset odata_valid", 32'(bus.odata_valid), 32'd0);
        check_output("reset odata", bus.odata, 32'd0);
        check_output("reset idata_ready", 32'(bus.idata_ready), 32'd1);

        run_beat("empty lut", 32'h7F807F80, 8'd0, 32'h0000_0000);

        bus.lut_wen   = 1'b1;
        bus.lut_waddr = 5'h03;
        bus.lut_wdata = 8'd16;
        #1;
        check_output("lut_wen blocks ready", 32'(bus.idata_ready), 32'd0);
        step();
        bus.lut_wen = 1'b0;
        write_lut(5'h12, 8'd8);
        run_beat("hi2 lo3 shift4", 32'h0000_0023, 8'd4, 32'h0000_0008);

        write_lut(5'h0F, 8'd255);
        write_lut(5'h17, 8'd255);
        run_beat("sat shift0", 32'h0000_7F23, 8'd0, 32'h0000_FF80);
        run_beat("shift16 zero", 32'h0000_7F23, 8'd16, 32'h0000_0000);
        run_beat("shift8", 32'h0000_7F00, 8'd8, 32'h0000_FE00);

        write_lut(5'h00, 8'd24);
        write_lut(5'h10, 8'd1);
`ifdef CONSMAX_ROUND_EN
        run_beat("round 24>>4", 32'h0000_0000, 8'd4, 32'h0202_0202);
`else
        run_beat("trunc 24>>4", 32'h0000_0000, 8'd4, 32'h0101_0101);
`endif

        in_data = '{32'h0000_0000, 32'h0000_0003, 32'h0000_0020,
                    32'h0000_0023, 32'h0000_000F, 32'h0000_0001};
        exp_out = '{32'h1818_1818, 32'h1818_1810, 32'h1818_18C0,
                    32'h1818_1880, 32'h1818_18FF, 32'h1818_1800};
        in_idx        = 0;
        out_idx       = 0;
        stall_left    = 0;
        stall_started = 1'b0;
        bus.cfg_shift = 8'd0;
        for (int cyc = 0; cyc < 60 && out_idx < 6; cyc++) begin
            bus.odata_ready = (stall_left == 0);
            if (in_idx < 6) begin
                bus.idata_valid = 1'b1;
                bus.idata       = in_data[in_idx];
            end else begin
                bus.idata_valid = 1'b0;
            end
            #1;
            if (!bus.odata_ready && bus.odata_valid && out_idx < 6) begin
                check_output("stall idata_ready", 32'(bus.idata_ready), 32'd0);
                check_output("stall odata held", bus.odata, exp_out[out_idx]);
            end
            if (bus.odata_valid && bus.odata_ready && out_idx < 6) begin
                check_output("stream order", bus.odata, exp_out[out_idx]);
                out_idx++;
                if (!stall_started) begin
                    stall_started = 1'b1;
                    stall_left    = 5;
                end
            end else if (stall_left > 0) begin
                stall_left--;
            end
            if (bus.idata_valid && bus.idata_ready) begin
                in_idx++;
            end
            @(posedge clk);
            #1;
        end
        bus.idata_valid = 1'b0;
        bus.odata_ready = 1'b1;
        check_output("stream all out", 32'(out_idx), 32'd6);
        check_output("stream all in", 32'(in_idx), 32'd6);
        check_output("stream drained", 32'(bus.odata_valid), 32'd0);
        step();

        bus.cfg_shift   = 8'd0;
        bus.idata_valid = 1'b1;
        bus.idata       = 32'h0000_0023;
        step();
        bus.idata       = 32'h0000_000F;
        step();
        bus.idata       = 32'h0000_0003;
        step();
        bus.idata_valid = 1'b0;
        check_output("pre-reset valid", 32'(bus.odata_valid), 32'd1);
        check_output("pre-reset data", bus.odata, 32'h1818_1880);
        rst = 1'b1;
        step();
        check_output("reset flush valid", 32'(bus.odata_valid), 32'd0);
        check_output("reset flush data", bus.odata, 32'd0);
        rst = 1'b0;
        step();
        step();
        check_output("no leftover beats", 32'(bus.odata_valid), 32'd0);

        run_beat("lut cleared", 32'h7F23230F, 8'd0, 32'h0000_0000);

        bus.lut_wen     = 1'b1;
        bus.lut_waddr   = 5'h12;
        bus.lut_wdata   = 8'd8;
        bus.idata_valid = 1'b1;
        bus.idata       = 32'h0000_0023;
        #1;
        check_output("write cycle blocks beat", 32'(bus.idata_ready), 32'd0);
        step();
        bus.idata_valid = 1'b0;
        bus.lut_wen     = 1'b0;
        write_lut(5'h03, 8'd16);
        step();
        check_output("blocked beat dropped", 32'(bus.odata_valid), 32'd0);
        run_beat("reloaded", 32'h0000_0023, 8'd0, 32'h0000_0080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
